mem_controller: RTL

Data-memory controller sitting directly below the MEM pipeline stage: it consumes that stage's MemRead/MemWrite/MemAddr/MemWriteData and returns MemReadData into its MemDataIn. It converts each single-cycle pipeline memory request into a handshaked access on the off-chip bus. It freezes the pipeline with Stall until the access completes, times out hung accesses, and flags misaligned addresses.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_bus_if.sv | 31 +++
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_controller.sv | 99 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory controller.
// State encoding, default timeout, error read value, bus widths.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } memState_t;

  localparam int DefTimeout = 16;
  localparam int ExtAw = 14;
  localparam logic [31:0] ErrRData = 32'h0;

endpackage

// File: rtl/mem_bus_if.sv
// Off-chip memory bus: request side driven by the controller.
// master: ExtCE/ExtWE/ExtAddr/ExtWData out, ExtRData/ExtReady in.
interface mem_bus_if;
  import mem_pkg::*;

  logic             ExtCE;
  logic             ExtWE;
  logic [ExtAw-1:0] ExtAddr;
  logic [31:0]      ExtWData;
  logic [31:0]      ExtRData;
  logic             ExtReady;

  modport master (
    output ExtCE,
    output ExtWE,
    output ExtAddr,
    output ExtWData,
    input  ExtRData,
    input  ExtReady
  );

  modport slave (
    input  ExtCE,
    input  ExtWE,
    input  ExtAddr,
    input  ExtWData,
    output ExtRData,
    output ExtReady
  );

endinterface

// File: rtl/mem_wait_counter.sv
// 8-bit wait counter for an outstanding external access.
// Ports: Clock, Reset, Clear, Enable in; TermCount out.
module mem_wait_counter
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DefTimeout
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic TermCount
);

  logic [7:0] count;

  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      count <= 8'd0;
    end else if (Enable) begin
      count <= count + 8'd1;
    end
  end

  // count holds cycles already spent, so the
  // TIMEOUT-th access cycle sees TIMEOUT-1.
  assign TermCount = Enable &&
    (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_controller.sv
// Turns single-cycle MEM-stage requests into handshaked bus accesses.
// Ports: Clock, Reset, Mem* pipeline side, Stall, errors, bus master.
module mem_controller
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DefTimeout
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] MemAddr,
  input  logic [31:0] MemWriteData,
  output logic [31:0] MemReadData,
  output logic        Stall,
  output logic        BusError,
  output logic        AlignError,
  mem_bus_if.master   bus
);

  memState_t state;
  logic      req;
  logic      aligned;
  logic      timeUp;

  assign req     = MemRead | MemWrite;
  assign aligned = (MemAddr[1:0] == 2'b00);

  // Stall must rise in the request cycle itself,
  // before any register can react.
  assign Stall = !Reset && (
    (state == IDLE && req && aligned) ||
    (state == ACCESS));

  mem_wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) waitCnt (
    .Clock    (Clock),
    .Reset    (Reset),
    .Clear    (state == IDLE),
    .Enable   (state == ACCESS),
    .TermCount(timeUp)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      MemReadData  <= '0;
      BusError     <= 1'b0;
      AlignError   <= 1'b0;
      bus.ExtCE    <= 1'b0;
      bus.ExtWE    <= 1'b0;
      bus.ExtAddr  <= '0;
      bus.ExtWData <= '0;
    end else begin
      AlignError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req && aligned) begin
            bus.ExtCE    <= 1'b1;
            bus.ExtWE    <= MemWrite;
            bus.ExtAddr  <= MemAddr[15:2];
            bus.ExtWData <= MemWriteData;
            state        <= ACCESS;
          end else if (req) begin
            AlignError  <= 1'b1;
            MemReadData <= ErrRData;
          end
        end
        ACCESS: begin
          // ready wins over a coincident timeout
          if (bus.ExtReady) begin
            if (!bus.ExtWE) begin
              MemReadData <= bus.ExtRData;
            end
            bus.ExtCE <= 1'b0;
            bus.ExtWE <= 1'b0;
            state     <= DONE;
          end else if (timeUp) begin
            if (!bus.ExtWE) begin
              MemReadData <= ErrRData;
            end
            BusError  <= 1'b1;
            bus.ExtCE <= 1'b0;
            bus.ExtWE <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          // request still on the inputs is the
          // one just served; ignore it
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
